// File: rtl/decompress_top.sv
// ML-KEM decompress: unpacks d-bit fields from 32-bit API words and writes 4 coefficients/clk.
// Optional sticky range check on compress12 data enabled by DECOMPRESS_MOD_CHECK_EN.

package decompress_pkg;
    localparam int ABR_MEM_ADDR_WIDTH = 15;

    typedef enum logic [1:0] {
        COMPRESS1  = 2'd0,
        COMPRESS5  = 2'd1,
        COMPRESS11 = 2'd2,
        COMPRESS12 = 2'd3
    } compress_mode_t;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'd0,
        RW_READ  = 2'd1,
        RW_WRITE = 2'd2
    } mem_rw_mode_e;

    typedef struct packed {
        mem_rw_mode_e                  rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;
endpackage

// One coefficient lane: y = round(x * q / 2^d), or pass-through for d = 12.
module decompress_lane
    import decompress_pkg::*;
(
    input  compress_mode_t mode,
    input  logic [11:0]    field,
    output logic [11:0]    coeff
`ifdef DECOMPRESS_MOD_CHECK_EN
    ,
    output logic           over_q
`endif
);
    logic [3:0]  d;
    logic [22:0] sum;

    always_comb begin
        d = 4'd12;
        unique case (mode)
            COMPRESS1:  d = 4'd1;
            COMPRESS5:  d = 4'd5;
            COMPRESS11: d = 4'd11;
            default:    d = 4'd12;
        endcase
        // Max for d=11 is 2047*3329 + 1024, which still fits in 23 bits.
        sum   = 23'(field) * 23'd3329 + (23'd1 << (d - 4'd1));
        coeff = (mode == COMPRESS12) ? field : 12'(sum >> d);
    end

`ifdef DECOMPRESS_MOD_CHECK_EN
    assign over_q = (mode == COMPRESS12) && (field >= 12'd3329);
`endif
endmodule

module decompress_top
    import decompress_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COEFF_PER_CLK = 4,
    parameter int REG_SIZE      = 24,
    parameter int BUF_W         = 96
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   zeroize,
    input  logic                                   decompress_enable,
    input  compress_mode_t                         mode,
    input  logic [2:0]                             num_poly,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0]          src_base_addr,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0]          dest_base_addr,
    output logic                                   api_rd_en,
    output logic [ABR_MEM_ADDR_WIDTH-1:0]          api_rd_addr,
    input  logic [DATA_WIDTH-1:0]                  api_rd_data,
    output mem_if_t                                mem_wr_req,
    output logic [COEFF_PER_CLK-1:0][REG_SIZE-1:0] mem_wr_data,
    output logic                                   range_error,
    output logic                                   decompress_done
);
    localparam int FILL_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                                state, state_nxt;
    compress_mode_t                        mode_q;
    logic [9:0]                            rd_left;
    logic [8:0]                            wr_left;
    logic [BUF_W-1:0]                      bits_q, bits_app;
    logic [FILL_W-1:0]                     fill_q, cons_w;
    logic [FILL_W:0]                       fill_need;
    logic                                  rd_vld;
    logic [ABR_MEM_ADDR_WIDTH-1:0]         wr_addr;
    logic                                  start, consume;
    logic [COEFF_PER_CLK-1:0][11:0]        coeff;

    function automatic logic [3:0] d_bits(input compress_mode_t m);
        unique case (m)
            COMPRESS1:  return 4'd1;
            COMPRESS5:  return 4'd5;
            COMPRESS11: return 4'd11;
            default:    return 4'd12;
        endcase
    endfunction

    // 256 coefficients * d bits / 32 bits per word = 8*d words per polynomial.
    function automatic logic [6:0] words_per_poly(input compress_mode_t m);
        return {d_bits(m), 3'b000};
    endfunction

    assign start     = (state == IDLE) && decompress_enable;
    assign cons_w    = FILL_W'({d_bits(mode_q), 2'b00});
    assign fill_need = {1'b0, fill_q} + (rd_vld ? (FILL_W+1)'(DATA_WIDTH) : '0);
    // Leave room for the word already in flight so the buffer never overflows.
    assign api_rd_en = (state == RUN) && (rd_left != '0) &&
                       (fill_need <= (FILL_W+1)'(BUF_W - DATA_WIDTH));
    assign consume   = ((state == RUN) || (state == FLUSH)) &&
                       (fill_q >= cons_w) && (wr_left != '0);
    assign bits_app  = bits_q | (rd_vld ? (BUF_W'(api_rd_data) << fill_q) : '0);
    assign decompress_done = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     state <= IDLE;
        else if (zeroize) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (decompress_enable) state_nxt = (num_poly == 3'd0) ? DONE : RUN;
            RUN:   if (api_rd_en && (rd_left == 10'd1)) state_nxt = FLUSH;
            // wr_left hits 0 once the final write is on the bus; done follows it.
            FLUSH: if (wr_left == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= COMPRESS1;
            rd_left     <= '0;
            wr_left     <= '0;
            bits_q      <= '0;
            fill_q      <= '0;
            rd_vld      <= 1'b0;
            api_rd_addr <= '0;
            wr_addr     <= '0;
            mem_wr_req  <= '0;
            mem_wr_data <= '0;
        end else if (zeroize) begin
            mode_q      <= COMPRESS1;
            rd_left     <= '0;
            wr_left     <= '0;
            bits_q      <= '0;
            fill_q      <= '0;
            rd_vld      <= 1'b0;
            api_rd_addr <= '0;
            wr_addr     <= '0;
            mem_wr_req  <= '0;
            mem_wr_data <= '0;
        end else begin
            rd_vld <= api_rd_en;
            if (start) begin
                mode_q      <= mode;
                rd_left     <= 10'(num_poly) * 10'(words_per_poly(mode));
                wr_left     <= {num_poly, 6'b0};
                bits_q      <= '0;
                fill_q      <= '0;
                api_rd_addr <= src_base_addr;
                wr_addr     <= dest_base_addr;
            end else begin
                if (api_rd_en) begin
                    rd_left     <= rd_left - 10'd1;
                    api_rd_addr <= api_rd_addr + 1'b1;
                end
                bits_q <= consume ? (bits_app >> cons_w) : bits_app;
                fill_q <= fill_q + (rd_vld ? FILL_W'(DATA_WIDTH) : '0) - (consume ? cons_w : '0);
                if (consume) begin
                    wr_left <= wr_left - 9'd1;
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            mem_wr_req  <= '0;
            mem_wr_data <= '0;
            if (consume) begin
                mem_wr_req.rd_wr_en <= RW_WRITE;
                mem_wr_req.addr     <= wr_addr;
                for (int i = 0; i < COEFF_PER_CLK; i++)
                    mem_wr_data[i] <= REG_SIZE'(coeff[i]);
            end
        end
    end

`ifdef DECOMPRESS_MOD_CHECK_EN
    logic [COEFF_PER_CLK-1:0] over;
    logic                     range_q;
`endif

    for (genvar i = 0; i < COEFF_PER_CLK; i++) begin : g_lane
        logic [11:0] lane_field;

        always_comb begin
            lane_field = '0;
            unique case (mode_q)
                COMPRESS1:  lane_field = 12'(bits_q[i]);
                COMPRESS5:  lane_field = 12'(bits_q[5*i +: 5]);
                COMPRESS11: lane_field = 12'(bits_q[11*i +: 11]);
                default:    lane_field = bits_q[12*i +: 12];
            endcase
        end

        decompress_lane u_lane (
            .mode  (mode_q),
            .field (lane_field),
            .coeff (coeff[i])
`ifdef DECOMPRESS_MOD_CHECK_EN
            ,
            .over_q(over[i])
`endif
        );
    end

`ifdef DECOMPRESS_MOD_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              range_q <= 1'b0;
        else if (zeroize || start) range_q <= 1'b0;
        else if (consume && |over) range_q <= 1'b1;
    end
    assign range_error = range_q;
`else
    assign range_error = 1'b0;
`endif

endmodule

// File: tb/tb_decompress_top.sv
// Directed bench for decompress_top: memory model for API reads, write monitor, immediate-assert checks.
module tb_decompress_top;
    import decompress_pkg::*;

`ifdef DECOMPRESS_MOD_CHECK_EN
    localparam logic EXP_RANGE = 1'b1;
`else
    localparam logic EXP_RANGE = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  zeroize = 1'b0;
    logic                  decompress_enable = 1'b0;
    compress_mode_t        mode = COMPRESS1;
    logic [2:0]            num_poly = '0;
    logic [14:0]           src_base_addr = '0;
    logic [14:0]           dest_base_addr = '0;
    logic                  api_rd_en;
    logic [14:0]           api_rd_addr;
    logic [31:0]           api_rd_data;
    mem_if_t               mem_wr_req;
    logic [3:0][23:0]      mem_wr_data;
    logic                  range_error;
    logic                  decompress_done;

    decompress_top dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .zeroize          (zeroize),
        .decompress_enable(decompress_enable),
        .mode             (mode),
        .num_poly         (num_poly),
        .src_base_addr    (src_base_addr),
        .dest_base_addr   (dest_base_addr),
        .api_rd_en        (api_rd_en),
        .api_rd_addr      (api_rd_addr),
        .api_rd_data      (api_rd_data),
        .mem_wr_req       (mem_wr_req),
        .mem_wr_data      (mem_wr_data),
        .range_error      (range_error),
        .decompress_done  (decompress_done)
    );

    always #5 clk = ~clk;

    logic [31:0] src_mem [0:1023];

    always @(posedge clk) if (api_rd_en === 1'b1) api_rd_data <= src_mem[api_rd_addr[9:0]];

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, en_cyc = 0, c_rd = 0, c_wr = 0, c_done = 0, c_bad = 0, c_aerr = 0;
    int          first_rd_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    logic [14:0] first_wr_addr = '0, last_wr_addr = '0, last_rd_addr = '0;
    logic [3:0][23:0] first_wr_data = '0;
    int          exp_coeff = 0;
    bit          chk_coeff = 1'b0;
    bit          to;

    // Observe the DUT on the falling edge; per-command tallies restart on each enable.
    always @(negedge clk) begin : mon
        int nb;
        cyc <= cyc + 1;
        if (decompress_enable) begin
            c_rd <= 0; c_wr <= 0; c_done <= 0; c_bad <= 0; c_aerr <= 0; en_cyc <= cyc;
        end else begin
            if (api_rd_en === 1'b1) begin
                if (c_rd == 0) first_rd_cyc <= cyc;
                last_rd_addr <= api_rd_addr;
                c_rd <= c_rd + 1;
            end
            if (mem_wr_req.rd_wr_en == RW_WRITE) begin
                if (c_wr == 0) begin
                    first_wr_addr <= mem_wr_req.addr;
                    first_wr_data <= mem_wr_data;
                    first_wr_cyc  <= cyc;
                end else if (mem_wr_req.addr != last_wr_addr + 15'd1) begin
                    c_aerr <= c_aerr + 1;
                end
                last_wr_addr <= mem_wr_req.addr;
                last_wr_cyc  <= cyc;
                c_wr <= c_wr + 1;
                nb = 0;
                for (int k = 0; k < 4; k++)
                    if (chk_coeff && (mem_wr_data[k] !== 24'(exp_coeff))) nb++;
                c_bad <= c_bad + nb;
            end
            if (decompress_done === 1'b1) begin
                c_done   <= c_done + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input int lo, input int hi, input logic [31:0] w);
        for (int a = lo; a <= hi; a++) src_mem[a] = w;
    endtask

    task automatic run_cmd(input compress_mode_t m, input logic [2:0] np,
                           input logic [14:0] src, input logic [14:0] dst, output bit timed_out);
        @(posedge clk); #1;
        mode = m; num_poly = np; src_base_addr = src; dest_base_addr = dst;
        decompress_enable = 1'b1;
        @(posedge clk); #1;
        decompress_enable = 1'b0;
        timed_out = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (c_done != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fill_mem(0, 1023, 32'hFFFF_FFFF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(api_rd_en), 0);
        chk("rst_rd_addr", 32'(api_rd_addr), 0);
        chk("rst_wr_req", 32'(mem_wr_req), 0);
        chk("rst_wr_data", 32'(|mem_wr_data), 0);
        chk("rst_done", 32'(decompress_done), 0);
        chk("rst_range", 32'(range_error), 0);
        reset_n = 1'b1;

        // compress1, all ones -> 1665
        exp_coeff = 1665; chk_coeff = 1'b1;
        run_cmd(COMPRESS1, 3'd1, 15'h000, 15'h010, to);
        chk("c1_timeout", 32'(to), 0);
        chk("c1_reads", c_rd, 8);
        chk("c1_writes", c_wr, 64);
        chk("c1_first_wr_addr", 32'(first_wr_addr), 32'h010);
        chk("c1_last_wr_addr", 32'(last_wr_addr), 32'h04F);
        chk("c1_bad_coeff", c_bad, 0);
        chk("c1_addr_gap", c_aerr, 0);
        chk("c1_done_cnt", c_done, 1);
        chk("c1_latency_ge2", 32'(first_wr_cyc >= first_rd_cyc + 2), 1);
        chk("c1_done_timing", done_cyc, last_wr_cyc + 1);

        // compress5, field 31 -> 3225
        exp_coeff = 3225;
        run_cmd(COMPRESS5, 3'd1, 15'h000, 15'h000, to);
        chk("c5_timeout", 32'(to), 0);
        chk("c5_reads", c_rd, 40);
        chk("c5_writes", c_wr, 64);
        chk("c5_bad_coeff", c_bad, 0);

        // compress5, field 0 -> 0
        fill_mem(0, 39, 32'h0);
        exp_coeff = 0;
        run_cmd(COMPRESS5, 3'd1, 15'h000, 15'h000, to);
        chk("c5z_timeout", 32'(to), 0);
        chk("c5z_writes", c_wr, 64);
        chk("c5z_bad_coeff", c_bad, 0);
        fill_mem(0, 39, 32'hFFFF_FFFF);

        // compress11, 4 polys, field 2047 -> 3327
        exp_coeff = 3327;
        run_cmd(COMPRESS11, 3'd4, 15'h100, 15'h040, to);
        chk("c11_timeout", 32'(to), 0);
        chk("c11_reads", c_rd, 352);
        chk("c11_last_rd_addr", 32'(last_rd_addr), 32'h25F);
        chk("c11_writes", c_wr, 256);
        chk("c11_last_wr_addr", 32'(last_wr_addr), 32'h13F);
        chk("c11_bad_coeff", c_bad, 0);
        chk("c11_addr_gap", c_aerr, 0);
        chk("c11_done_cnt", c_done, 1);
        chk("c11_done_timing", done_cyc, last_wr_cyc + 1);

        // compress12 pass-through and range flag
        src_mem[10'h300] = 32'h0010_0FFF;
        fill_mem(32'h301, 32'h35F, 32'h0);
        chk_coeff = 1'b0;
        run_cmd(COMPRESS12, 3'd1, 15'h300, 15'h000, to);
        chk("c12_timeout", 32'(to), 0);
        chk("c12_writes", c_wr, 64);
        chk("c12_coeff0", 32'(first_wr_data[0]), 32'hFFF);
        chk("c12_coeff1", 32'(first_wr_data[1]), 32'h100);
        chk("c12_coeff2", 32'(first_wr_data[2]), 32'h000);
        chk("c12_range", 32'(range_error), 32'(EXP_RANGE));

        // zeroize around write 20 of compress11
        @(posedge clk); #1;
        mode = COMPRESS11; num_poly = 3'd1; src_base_addr = 15'h000; dest_base_addr = 15'h000;
        decompress_enable = 1'b1;
        @(posedge clk); #1;
        decompress_enable = 1'b0;
        to = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (c_wr >= 20) begin
                to = 1'b0;
                break;
            end
        end
        chk("zc_reach_w20", 32'(to), 0);
        chk("zc_range_cleared", 32'(range_error), 0);
        zeroize = 1'b1;
        @(posedge clk); #1;
        chk("zc_rd_en", 32'(api_rd_en), 0);
        chk("zc_rd_addr", 32'(api_rd_addr), 0);
        chk("zc_wr_req", 32'(mem_wr_req), 0);
        chk("zc_wr_data", 32'(|mem_wr_data), 0);
        chk("zc_done", 32'(decompress_done), 0);
        zeroize = 1'b0;
        repeat (150) @(negedge clk);
        chk("zc_no_done", c_done, 0);

        // fresh command after zeroize
        exp_coeff = 3327; chk_coeff = 1'b1;
        run_cmd(COMPRESS11, 3'd1, 15'h000, 15'h080, to);
        chk("post_timeout", 32'(to), 0);
        chk("post_reads", c_rd, 88);
        chk("post_writes", c_wr, 64);
        chk("post_bad_coeff", c_bad, 0);
        chk("post_last_wr_addr", 32'(last_wr_addr), 32'h0BF);
        chk("post_done_cnt", c_done, 1);

        // num_poly = 0
        run_cmd(COMPRESS5, 3'd0, 15'h000, 15'h000, to);
        chk("np0_timeout", 32'(to), 0);
        chk("np0_reads", c_rd, 0);
        chk("np0_writes", c_wr, 0);
        chk("np0_done_cnt", c_done, 1);
        chk("np0_done_timing", done_cyc, en_cyc + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
